// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

  // Next-PC source selected by the control logic.
  typedef enum logic [1:0] {
    PcSeq    = 2'd0,
    PcBranch = 2'd1,
    PcJalr   = 2'd2,
    PcTrap   = 2'd3
  } pc_sel_e;

  // Run/halt control state.
  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StHalted = 1'b1
  } pc_state_e;

  // Sequential increment (also the link offset).
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_if.sv
// Control/branch side <-> PC unit bundle. Trace signals exist only with PC_TRACE_EN.
interface pc_if import pc_pkg::*; #(
  parameter int unsigned XLEN = 32
`ifdef PC_TRACE_EN
  , parameter int unsigned TRACE_DEPTH = 8
`endif
) ();

  logic            stall;
  logic            halt_req;
  logic            resume;
  pc_sel_e         pc_sel;
  logic            branch_taken;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] jalr_base;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus4;
  logic            misaligned;
  logic [XLEN-1:0] bad_target;
  logic            halted;
`ifdef PC_TRACE_EN
  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx;
  logic [XLEN-1:0]                trace_data;
  logic [$clog2(TRACE_DEPTH):0]   trace_count;
`endif

  // Control/branch logic side.
  modport master (
    output stall, halt_req, resume, pc_sel, branch_taken, imm, jalr_base,
`ifdef PC_TRACE_EN
    output trace_idx,
    input  trace_data, trace_count,
`endif
    input  pc_out, pc_plus4, misaligned, bad_target, halted
  );

  // PC unit side.
  modport slave (
    input  stall, halt_req, resume, pc_sel, branch_taken, imm, jalr_base,
`ifdef PC_TRACE_EN
    input  trace_idx,
    output trace_data, trace_count,
`endif
    output pc_out, pc_plus4, misaligned, bad_target, halted
  );

endinterface

// File: rtl/pc_trace_buf.sv
// Circular log of non-sequential PC loads; read side indexes back from the newest entry.
module pc_trace_buf #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IdxW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_data,
  input  logic [IdxW-1:0] rd_idx,
  output logic [XLEN-1:0] rd_data,
  output logic [IdxW:0]   count
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [IdxW-1:0] wr_ptr_q;
  logic [IdxW:0]   count_q;
  logic [IdxW-1:0] rd_pos;

  // Write pointer wraps naturally; count saturates at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
      wr_ptr_q        <= wr_ptr_q + 1'b1;
      if (count_q != (IdxW + 1)'(DEPTH)) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Newest entry sits just behind the write pointer; unfilled slots read as zero.
  always_comb begin
    rd_pos  = wr_ptr_q - 1'b1 - rd_idx;
    rd_data = '0;
    if ({1'b0, rd_idx} < count_q) begin
      rd_data = mem_q[rd_pos];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC selection, run/halt FSM, misaligned-target trap.
// Optional redirect trace buffer enabled by defining PC_TRACE_EN.
module pc_unit import pc_pkg::*; #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     IALIGN       = 4,
  parameter int unsigned     TRACE_DEPTH  = 8
) (
  input logic clk,
  input logic rst,
  pc_if.slave bus
);

  localparam logic [XLEN-1:0] AlignMask = XLEN'(IALIGN - 1);

  if (!(IALIGN == 2 || IALIGN == 4)) begin : g_bad_ialign
    $error("IALIGN must be 2 or 4");
  end
  if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("TRACE_DEPTH must be a power of 2, at least 2");
  end

  pc_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic            mis_q;
  logic [XLEN-1:0] bad_q;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] redirect_target;
  logic            redirect;
  logic            target_bad;
  logic            advance;
  logic            take_trap;
  logic            pc_load;
  logic [XLEN-1:0] pc_next;

  assign pc_plus4    = pc_q + XLEN'(PC_INC);
  assign br_target   = pc_q + bus.imm;
  assign jalr_target = (bus.jalr_base + bus.imm) & ~XLEN'(1);

  // Traps win over halt and stall; everything else needs a free-running cycle.
  assign take_trap = (state_q == StRun) && (bus.pc_sel == PcTrap);
  assign advance   = (state_q == StRun) && !bus.halt_req && !bus.stall;

  // Pick the redirect candidate and decide what the PC loads this cycle.
  always_comb begin
    redirect        = 1'b0;
    redirect_target = br_target;
    unique case (bus.pc_sel)
      PcBranch: redirect = bus.branch_taken;
      PcJalr: begin
        redirect        = 1'b1;
        redirect_target = jalr_target;
      end
      default: ;
    endcase
    target_bad = redirect && ((redirect_target & AlignMask) != '0);

    pc_load = 1'b0;
    pc_next = pc_plus4;
    if (take_trap) begin
      pc_load = 1'b1;
      pc_next = TRAP_VECTOR;
    end else if (advance) begin
      pc_load = 1'b1;
      if (target_bad) begin
        pc_next = TRAP_VECTOR;
      end else if (redirect) begin
        pc_next = redirect_target;
      end
    end
  end

  // Run/halt FSM with registered PC, misaligned pulse and captured bad target.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StRun;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
      bad_q   <= '0;
    end else begin
      mis_q <= 1'b0;
      if (pc_load) begin
        pc_q <= pc_next;
      end
      if (advance && target_bad) begin
        mis_q <= 1'b1;
        bad_q <= redirect_target;
      end
      unique case (state_q)
        StRun:    if (bus.halt_req) state_q <= StHalted;
        StHalted: if (bus.resume && !bus.halt_req) state_q <= StRun;
        default:  state_q <= StRun;
      endcase
    end
  end

  assign bus.pc_out     = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.misaligned = mis_q;
  assign bus.bad_target = bad_q;
  assign bus.halted     = (state_q == StHalted);

`ifdef PC_TRACE_EN
  logic trace_we;

  // Every non-sequential load is logged, including the misaligned-target trap.
  assign trace_we = take_trap || (advance && redirect);

  pc_trace_buf #(
    .XLEN  (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (trace_we),
    .wr_data (pc_next),
    .rd_idx  (bus.trace_idx),
    .rd_data (bus.trace_data),
    .count   (bus.trace_count)
  );
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboarded bench for pc_unit: directed scenarios then random traffic vs. a reference model.
module tb_pc_unit;
  import pc_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int          TD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_if bus ();

  pc_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        mis;
    logic [31:0] bad;
    logic        halted;
`ifdef PC_TRACE_EN
    logic [31:0] tcount;
    logic [31:0] tdata;
`endif
  } exp_t;

  exp_t sb[$];

  // Reference state
  logic [31:0] m_pc = RV;
  logic        m_mis = 1'b0;
  logic [31:0] m_bad = '0;
  logic        m_halted = 1'b0;
  logic [31:0] m_trace[$];
  int          tidx = 0;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void log_pc(input logic [31:0] v);
    m_trace.push_front(v);
    if (m_trace.size() > TD) void'(m_trace.pop_back());
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expected post-edge state.
  task automatic drive(input logic r, input pc_sel_e sel, input logic tk, input logic [31:0] im,
                       input logic [31:0] jb, input logic st, input logic hr, input logic rs);
    logic [31:0] tgt;
    exp_t e;
    @(negedge clk);
    rst              = r;
    bus.pc_sel       = sel;
    bus.branch_taken = tk;
    bus.imm          = im;
    bus.jalr_base    = jb;
    bus.stall        = st;
    bus.halt_req     = hr;
    bus.resume       = rs;
`ifdef PC_TRACE_EN
    bus.trace_idx    = 3'(tidx);
`endif
    if (!r) begin
      m_pc = RV; m_mis = 1'b0; m_bad = '0; m_halted = 1'b0;
      m_trace.delete();
    end else if (m_halted) begin
      m_mis = 1'b0;
      if (rs && !hr) m_halted = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (sel == PcTrap) begin
        m_pc = TV;
        log_pc(TV);
      end else if (hr || st) begin
        // hold
      end else if (sel == PcSeq || (sel == PcBranch && !tk)) begin
        m_pc = m_pc + 32'd4;
      end else begin
        tgt = (sel == PcBranch) ? m_pc + im : (jb + im) & 32'hFFFF_FFFE;
        if (tgt % 4 != 0) begin
          m_pc = TV; m_mis = 1'b1; m_bad = tgt;
          log_pc(TV);
        end else begin
          m_pc = tgt;
          log_pc(tgt);
        end
      end
      if (hr) m_halted = 1'b1;
    end
    e.pc = m_pc; e.mis = m_mis; e.bad = m_bad; e.halted = m_halted;
`ifdef PC_TRACE_EN
    e.tcount = m_trace.size();
    e.tdata  = (tidx < m_trace.size()) ? m_trace[tidx] : 32'h0;
`endif
    sb.push_back(e);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, PcSeq, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pop one expectation per clock edge and compare everything visible.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_pc", bus.pc_out, e.pc);
        check("sb_pc_plus4", bus.pc_plus4, e.pc + 32'd4);
        check("sb_misaligned", 32'(bus.misaligned), 32'(e.mis));
        check("sb_bad_target", bus.bad_target, e.bad);
        check("sb_halted", 32'(bus.halted), 32'(e.halted));
`ifdef PC_TRACE_EN
        check("sb_trace_count", 32'(bus.trace_count), e.tcount);
        check("sb_trace_data", bus.trace_data, e.tdata);
`endif
      end
    end
  end

  initial begin
    bus.stall = 1'b0; bus.halt_req = 1'b0; bus.resume = 1'b0; bus.pc_sel = PcSeq;
    bus.branch_taken = 1'b0; bus.imm = '0; bus.jalr_base = '0;
`ifdef PC_TRACE_EN
    bus.trace_idx = '0;
`endif

    // Reset then sequential fetch
    drive(1'b0, PcSeq, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, PcSeq, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    settle(); check("reset_pc", bus.pc_out, 32'h0);
    check("reset_halted", 32'(bus.halted), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      seq(1); settle(); check("seq_pc", bus.pc_out, 32'(4 * i));
    end

    // Branch / JALR from 0x10
    drive(1'b1, PcBranch, 1'b1, 32'h30, 0, 1'b0, 1'b0, 1'b0);
    settle(); check("branch_taken", bus.pc_out, 32'h40);
    drive(1'b1, PcBranch, 1'b0, 32'h30, 0, 1'b0, 1'b0, 1'b0);
    settle(); check("branch_not_taken", bus.pc_out, 32'h44);
    drive(1'b1, PcJalr, 1'b0, 32'h0, 32'h81, 1'b0, 1'b0, 1'b0);
    settle(); check("jalr_clear_lsb", bus.pc_out, 32'h80);

    // Stall at 0x8, then trap during stall
    drive(1'b0, PcSeq, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    seq(2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, PcSeq, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      settle(); check("stall_hold", bus.pc_out, 32'h8);
    end
    drive(1'b1, PcTrap, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    settle(); check("trap_over_stall", bus.pc_out, TV);

    // Misaligned JALR
    drive(1'b1, PcJalr, 1'b0, 32'h0, 32'h102, 1'b0, 1'b0, 1'b0);
    settle(); check("mis_pc", bus.pc_out, TV);
    check("mis_flag", 32'(bus.misaligned), 32'h1);
    check("mis_bad_target", bus.bad_target, 32'h102);
    seq(1); settle(); check("mis_pulse_end", 32'(bus.misaligned), 32'h0);
    check("bad_target_held", bus.bad_target, 32'h102);

    // Halt / resume
    drive(1'b0, PcSeq, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    seq(3);
    drive(1'b1, PcSeq, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    settle(); check("halt_enter", 32'(bus.halted), 32'h1);
    check("halt_pc", bus.pc_out, 32'hC);
    seq(1);
    drive(1'b1, PcTrap, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    settle(); check("halt_ignores_trap", bus.pc_out, 32'hC);
    drive(1'b1, PcSeq, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    settle(); check("halt_resume_conflict", 32'(bus.halted), 32'h1);
    drive(1'b1, PcSeq, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    settle(); check("resume", 32'(bus.halted), 32'h0);
    seq(1); settle(); check("resume_seq", bus.pc_out, 32'h10);
    drive(1'b1, PcSeq, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, PcSeq, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    settle(); check("reset_from_halt_pc", bus.pc_out, 32'h0);
    check("reset_from_halt", 32'(bus.halted), 32'h0);

    // Wrap-around
    drive(1'b1, PcJalr, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    settle(); check("wrap_plus4", bus.pc_plus4, 32'h0);
    seq(1); settle(); check("wrap_pc", bus.pc_out, 32'h0);
    check("wrap_no_flag", 32'(bus.misaligned), 32'h0);

`ifdef PC_TRACE_EN
    // Trace: 10 taken branches of +0x10 from 0
    drive(1'b0, PcSeq, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    settle(); check("trace_empty_count", 32'(bus.trace_count), 32'h0);
    check("trace_empty_data", bus.trace_data, 32'h0);
    for (int i = 0; i < 10; i++) drive(1'b1, PcBranch, 1'b1, 32'h10, 0, 1'b0, 1'b0, 1'b0);
    settle(); check("trace_count_sat", 32'(bus.trace_count), 32'd8);
    bus.trace_idx = 3'd0; #1; check("trace_newest", bus.trace_data, 32'hA0);
    bus.trace_idx = 3'd7; #1; check("trace_oldest", bus.trace_data, 32'h30);
`endif

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] im;
      logic [31:0] jb;
      im = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) im = -im;
      if ($urandom_range(0, 9) == 0) im = $urandom();
      jb = $urandom();
      tidx = $urandom_range(0, TD - 1);
      drive($urandom_range(0, 49) != 0, pc_sel_e'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), im, jb, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
